// File: rtl/l2_mem_if.sv
// L1 miss-interface bundle between the cache controller (master) and the L2 responder (slave).
interface l2_mem_if #(
    parameter int BLOCK_W = 128
);
    logic               read_l2;
    logic               write_l2;
    logic [31:0]        addr;
    logic [BLOCK_W-1:0] wdata;
    logic [BLOCK_W-1:0] rdata;
    logic               l2_ack;
    logic               write_done;

    modport master (
        output read_l2, write_l2, addr, wdata,
        input  rdata, l2_ack, write_done
    );

    modport slave (
        input  read_l2, write_l2, addr, wdata,
        output rdata, l2_ack, write_done
    );
endinterface

// File: rtl/l2_mem_responder.sv
// L2 block-memory responder: serves L1 fills and dirty write-backs with programmable latency.
module l2_mem_responder #(
    parameter int RD_LAT     = 3,
    parameter int WR_LAT     = 2,
    parameter int DEPTH_LOG2 = 10,
    parameter int BLOCK_W    = 128
) (
    input  logic       clk,
    input  logic       reset,
    l2_mem_if.slave    bus,
    output logic       busy,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        WB   = 3'b001,
        WACK = 3'b010,
        FILL = 3'b011,
        RESP = 3'b100
    } state_t;

    localparam int         DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_CNT = 4'(WR_LAT - 1);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [BLOCK_W-1:0]      wdata_q, wdata_d;
    logic [BLOCK_W-1:0]      rdata_q, rdata_d;
    logic                    ack_q, ack_d;
    logic                    done_q, done_d;
    logic                    mem_we;
    logic [DEPTH_LOG2-1:0]   req_idx;
    logic                    unused_addr_bits;

    logic [BLOCK_W-1:0]      mem_q [DEPTH];

    assign req_idx          = bus.addr[DEPTH_LOG2+3:4];
    assign unused_addr_bits = ^{bus.addr[31:DEPTH_LOG2+4], bus.addr[3:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = ack_q;
        done_d  = done_q;
        mem_we  = 1'b0;

        case (state_q)
            IDLE: begin
                // Write-back wins over a simultaneous fill; the fill follows from WACK.
                if (bus.write_l2) begin
                    idx_d   = req_idx;
                    wdata_d = bus.wdata;
                    cnt_d   = WR_CNT;
                    state_d = WB;
                end else if (bus.read_l2) begin
                    idx_d   = req_idx;
                    cnt_d   = RD_CNT;
                    state_d = FILL;
                end
            end
            WB: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    mem_we  = 1'b1;
                    done_d  = 1'b1;
                    state_d = WACK;
                end
            end
            WACK: begin
                if (!bus.write_l2) begin
                    done_d = 1'b0;
                    if (bus.read_l2) begin
                        idx_d   = req_idx;
                        cnt_d   = RD_CNT;
                        state_d = FILL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FILL: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdata_d = mem_q[idx_q];
                    ack_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (!bus.read_l2) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
        end
    end

    // Block storage and the captured write-back data are deliberately outside reset.
    always_ff @(posedge clk) begin
        wdata_q <= wdata_d;
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign bus.rdata      = rdata_q;
    assign bus.l2_ack     = ack_q;
    assign bus.write_done = done_q;
    assign busy           = (state_q != IDLE);
    assign state          = state_q;

endmodule

// File: tb/tb_l2_mem_responder.sv
// Scoreboard bench for l2_mem_responder: one instance at default latency, one at RD_LAT=WR_LAT=1.
module tb_l2_mem_responder;

    localparam logic [127:0] PAT_A5   = {16{8'hA5}};
    localparam logic [127:0] PAT_DEAD = {8{16'hDEAD}};
    localparam logic [127:0] PAT_W3   = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    localparam logic [127:0] PAT_W5   = {4{32'h5A5A_0F0F}};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       busy_a, busy_b;
    logic [2:0] st_a, st_b;

    always #5 clk = ~clk;

    l2_mem_if #(.BLOCK_W(128)) ifa ();
    l2_mem_if #(.BLOCK_W(128)) ifb ();

    l2_mem_responder #(.RD_LAT(3), .WR_LAT(2), .DEPTH_LOG2(10), .BLOCK_W(128)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa), .busy(busy_a), .state(st_a)
    );

    l2_mem_responder #(.RD_LAT(1), .WR_LAT(1), .DEPTH_LOG2(10), .BLOCK_W(128)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb), .busy(busy_b), .state(st_b)
    );

    typedef struct {
        logic [127:0] data;
        int           cyc;
    } exp_t;

    exp_t qa_rd[$];
    exp_t qa_wr[$];
    exp_t qb_rd[$];
    exp_t qb_wr[$];

    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return ifa.l2_ack;
            1:       return ifa.write_done;
            2:       return ifb.l2_ack;
            default: return ifb.write_done;
        endcase
    endfunction

    task automatic wait_hi(input int sel, input string nm);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sig(sel)) return;
        end
        tests++;
        fails++;
        $display("FAIL %s: timeout, got 0 required 1", nm);
    endtask

    // Monitor: every rising ack/done pops the oldest expectation and checks data and edge.
    logic pa_ack = 1'b0, pa_done = 1'b0, pb_ack = 1'b0, pb_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (ifa.l2_ack && !pa_ack) begin
            if (qa_rd.size() == 0) begin
                tests++; fails++;
                $display("FAIL a_unexpected_ack: got 1 required 0");
            end else begin
                e = qa_rd.pop_front();
                chk("a_rdata", ifa.rdata, e.data);
                chk("a_ack_edge", 128'(cyc), 128'(e.cyc));
            end
        end
        if (ifa.write_done && !pa_done) begin
            if (qa_wr.size() == 0) begin
                tests++; fails++;
                $display("FAIL a_unexpected_done: got 1 required 0");
            end else begin
                e = qa_wr.pop_front();
                chk("a_done_edge", 128'(cyc), 128'(e.cyc));
            end
        end
        if (ifb.l2_ack && !pb_ack) begin
            if (qb_rd.size() == 0) begin
                tests++; fails++;
                $display("FAIL b_unexpected_ack: got 1 required 0");
            end else begin
                e = qb_rd.pop_front();
                chk("b_rdata", ifb.rdata, e.data);
                chk("b_ack_edge", 128'(cyc), 128'(e.cyc));
            end
        end
        if (ifb.write_done && !pb_done) begin
            if (qb_wr.size() == 0) begin
                tests++; fails++;
                $display("FAIL b_unexpected_done: got 1 required 0");
            end else begin
                e = qb_wr.pop_front();
                chk("b_done_edge", 128'(cyc), 128'(e.cyc));
            end
        end
        pa_ack  <= ifa.l2_ack;
        pa_done <= ifa.write_done;
        pb_ack  <= ifb.l2_ack;
        pb_done <= ifb.write_done;
    end

    task automatic fill_a(input logic [31:0] a, input logic [127:0] d);
        @(negedge clk);
        ifa.read_l2 = 1'b1;
        ifa.addr    = a;
        qa_rd.push_back('{data: d, cyc: cyc + 4});
        @(negedge clk);
        ifa.addr = 32'hFFFF_FFF0;
        wait_hi(0, "a_fill_ack");
        ifa.read_l2 = 1'b0;
        @(negedge clk);
        chk("a_ack_drop", 128'(ifa.l2_ack), 128'(0));
        chk("a_idle_after_fill", 128'(st_a), 128'(0));
    endtask

    task automatic write_a(input logic [31:0] a, input logic [127:0] d);
        @(negedge clk);
        ifa.write_l2 = 1'b1;
        ifa.addr     = a;
        ifa.wdata    = d;
        qa_wr.push_back('{data: '0, cyc: cyc + 3});
        @(negedge clk);
        ifa.addr = 32'hFFFF_FFF0;
        wait_hi(1, "a_wb_done");
        ifa.write_l2 = 1'b0;
        @(negedge clk);
        chk("a_done_drop", 128'(ifa.write_done), 128'(0));
        chk("a_idle_after_wb", 128'(st_a), 128'(0));
    endtask

    initial begin
        ifa.read_l2 = 1'b0; ifa.write_l2 = 1'b0; ifa.addr = '0; ifa.wdata = '0;
        ifb.read_l2 = 1'b0; ifb.write_l2 = 1'b0; ifb.addr = '0; ifb.wdata = '0;
        for (int i = 0; i < 1024; i++) begin
            dut_a.mem_q[i] = '0;
            dut_b.mem_q[i] = '0;
        end
        dut_a.mem_q[10'h180] = PAT_A5;
        dut_a.mem_q[10'h1C0] = PAT_DEAD;

        repeat (2) @(negedge clk);
        chk("rst_state", 128'(st_a), 128'(0));
        chk("rst_busy", 128'(busy_a), 128'(0));
        chk("rst_ack", 128'(ifa.l2_ack), 128'(0));
        chk("rst_done", 128'(ifa.write_done), 128'(0));
        chk("rst_rdata", ifa.rdata, 128'(0));
        chk("rst_b_busy", 128'(busy_b), 128'(0));
        reset = 1'b1;

        // Plain fill, write-back, then read-after-write.
        fill_a(32'h0000_1800, PAT_A5);
        write_a(32'h0000_1000, 128'h1234);
        fill_a(32'h0000_1000, 128'h1234);

        // Dirty conflict miss: simultaneous requests, write first, fill straight from WACK.
        @(negedge clk);
        ifa.write_l2 = 1'b1;
        ifa.read_l2  = 1'b1;
        ifa.addr     = 32'h0000_2000;
        ifa.wdata    = PAT_W3;
        qa_wr.push_back('{data: '0, cyc: cyc + 3});
        wait_hi(1, "a_dirty_done");
        chk("a_dirty_wack", 128'(st_a), 128'(2));
        ifa.write_l2 = 1'b0;
        ifa.addr     = 32'h0000_1C00;
        qa_rd.push_back('{data: PAT_DEAD, cyc: cyc + 4});
        @(negedge clk);
        chk("a_wack_to_fill", 128'(st_a), 128'(3));
        chk("a_dirty_done_drop", 128'(ifa.write_done), 128'(0));
        ifa.addr = 32'hFFFF_FFF0;
        wait_hi(0, "a_dirty_ack");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("a_hold_ack", 128'(ifa.l2_ack), 128'(1));
            chk("a_hold_rdata", ifa.rdata, PAT_DEAD);
            chk("a_hold_state", 128'(st_a), 128'(4));
        end
        ifa.read_l2 = 1'b0;
        @(negedge clk);
        chk("a_hold_exit_ack", 128'(ifa.l2_ack), 128'(0));
        chk("a_hold_exit_state", 128'(st_a), 128'(0));
        fill_a(32'h0000_2000, PAT_W3);

        // Asynchronous reset in the middle of a fill.
        @(negedge clk);
        ifa.read_l2 = 1'b1;
        ifa.addr    = 32'h0000_1800;
        @(negedge clk);
        chk("a_midfill_busy", 128'(busy_a), 128'(1));
        chk("a_midfill_state", 128'(st_a), 128'(3));
        #2 reset = 1'b0;
        #1;
        chk("a_arst_ack", 128'(ifa.l2_ack), 128'(0));
        chk("a_arst_busy", 128'(busy_a), 128'(0));
        chk("a_arst_state", 128'(st_a), 128'(0));
        chk("a_arst_rdata", ifa.rdata, 128'(0));
        ifa.read_l2 = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Reset before the write-back counter expires discards the write.
        @(negedge clk);
        ifa.write_l2 = 1'b1;
        ifa.addr     = 32'h0000_1800;
        ifa.wdata    = 128'hBAD;
        @(negedge clk);
        chk("a_midwb_state", 128'(st_a), 128'(1));
        #2 reset = 1'b0;
        #1;
        chk("a_arst_wb_state", 128'(st_a), 128'(0));
        ifa.write_l2 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        fill_a(32'h0000_1800, PAT_A5);
        fill_a(32'h0000_1000, 128'h1234);

        // Minimum latency instance.
        @(negedge clk);
        ifb.write_l2 = 1'b1;
        ifb.addr     = 32'h0000_3000;
        ifb.wdata    = PAT_W5;
        qb_wr.push_back('{data: '0, cyc: cyc + 2});
        wait_hi(3, "b_wb_done");
        ifb.write_l2 = 1'b0;
        @(negedge clk);
        chk("b_done_drop", 128'(ifb.write_done), 128'(0));
        chk("b_idle_after_wb", 128'(st_b), 128'(0));
        @(negedge clk);
        ifb.read_l2 = 1'b1;
        qb_rd.push_back('{data: PAT_W5, cyc: cyc + 2});
        wait_hi(2, "b_fill_ack");
        ifb.read_l2 = 1'b0;
        @(negedge clk);
        chk("b_ack_drop", 128'(ifb.l2_ack), 128'(0));
        chk("b_idle_after_fill", 128'(st_b), 128'(0));

        repeat (2) @(negedge clk);
        chk("a_rd_queue_empty", 128'(qa_rd.size()), 128'(0));
        chk("a_wr_queue_empty", 128'(qa_wr.size()), 128'(0));
        chk("b_rd_queue_empty", 128'(qb_rd.size()), 128'(0));
        chk("b_wr_queue_empty", 128'(qb_wr.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
